// File: rtl/rf_parallel_mc.sv
// rf_parallel_mc: multi-channel RF frequency-word controller.
// Buffers NUM_CH-wide word sets in a FIFO and presents the active set on
// o_rf_freq. It advances on TX-over (MODE=0) or on an accepted pre-CPI edge
// (MODE=1). Each accepted pre-CPI rising edge produces a CTRL_LEN-cycle
// control strobe followed by a GUARD_LEN-cycle dead time.
module rf_parallel_mc #(
    parameter int NUM_CH      = 2,
    parameter int FW          = 16,
    parameter int DEPTH       = 8,
    parameter int CTRL_LEN    = 200,
    parameter int GUARD_LEN   = 16,
    parameter int SYNC_STAGES = 3,
    parameter int MODE        = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*FW-1:0]       i_rf_freq,
    input  logic                       i_rf_freq_vld,
    input  logic                       i_init,
    input  logic                       i_stop,
    input  logic                       i_pre_cpi,
    input  logic                       i_tx_over_flag,
    output logic [NUM_CH*FW-1:0]       o_rf_freq,
    output logic                       o_rf_freq_ctrl,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_fifo_level,
    output logic                       o_ovf,
    output logic                       o_udf
);

    localparam int WW   = NUM_CH * FW;
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXL = (CTRL_LEN > GUARD_LEN) ? CTRL_LEN : GUARD_LEN;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [CW-1:0] CTRL_LAST  = CW'(CTRL_LEN - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_LEN > 0) ? (GUARD_LEN - 1) : 0);
    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CTRL  = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    // Pre-CPI synchroniser, history flop and registered edge pulse
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   pedge_q, pedge_d;

    // Sequencer state
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ctrl_q, ctrl_d;
    logic                   busy_q, busy_d;

    // FIFO storage and flags
    logic [WW-1:0]          mem_q [DEPTH];
    logic [WW-1:0]          mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;
    logic                   first_q, first_d;
    logic [WW-1:0]          freq_q, freq_d;

    // Derived control
    logic                   empty_s;
    logic                   auto_pop_s;
    logic                   pop_req_s;
    logic                   pop_do_s;
    logic                   push_ok_s;
    logic [WW-1:0]          head_s;

    // Edge detection: shift the async marker in, pulse one cycle per rise
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_pre_cpi};
        hist_d  = sync_q[SYNC_STAGES-1];
        pedge_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // Pop/push qualification shared by the FIFO and output register
    always_comb begin
        empty_s    = (level_q == {LW{1'b0}});
        head_s     = mem_q[rd_ptr_q];
        auto_pop_s = ~first_q & ~empty_s;
        if (state_q == S_IDLE) begin
            pop_req_s = 1'b0;
        end else if (MODE == 0) begin
            pop_req_s = first_q & i_tx_over_flag;
        end else begin
            pop_req_s = first_q & (state_q == S_ARMED) & pedge_q;
        end
        pop_do_s  = auto_pop_s | (pop_req_s & ~empty_s);
        // A pop in the same cycle frees the slot the push needs
        push_ok_s = i_rf_freq_vld & ((level_q < FULL_LVL) | pop_do_s);
    end

    // FIFO, active word set and sticky flags; i_init flushes everything
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        first_d  = first_q;
        freq_d   = freq_q;
        if (i_init) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {LW{1'b0}};
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            first_d  = 1'b0;
            freq_d   = {WW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = i_rf_freq;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_do_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                freq_d   = head_s;
            end else begin
                rd_ptr_d = rd_ptr_q;
                freq_d   = freq_q;
            end
            level_d = level_q + {{(LW-1){1'b0}}, push_ok_s}
                              - {{(LW-1){1'b0}}, pop_do_s};
            if (i_rf_freq_vld && !push_ok_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (pop_req_s && empty_s) begin
                udf_d = 1'b1;
            end else begin
                udf_d = udf_q;
            end
            if (auto_pop_s) begin
                first_d = 1'b1;
            end else begin
                first_d = first_q;
            end
        end
    end

    // Strobe sequencer: IDLE -> ARMED -> CTRL -> GUARD -> ARMED
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        if (i_init) begin
            state_d = S_ARMED;
            cnt_d   = {CW{1'b0}};
            ctrl_d  = 1'b0;
        end else if (i_stop) begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
            ctrl_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ctrl_d = 1'b0;
                end
                S_ARMED: begin
                    if (pedge_q) begin
                        state_d = S_CTRL;
                        cnt_d   = {CW{1'b0}};
                        ctrl_d  = 1'b1;
                    end else begin
                        ctrl_d  = 1'b0;
                    end
                end
                S_CTRL: begin
                    if (cnt_q == CTRL_LAST) begin
                        ctrl_d  = 1'b0;
                        cnt_d   = {CW{1'b0}};
                        state_d = (GUARD_LEN > 0) ? S_GUARD : S_ARMED;
                    end else begin
                        ctrl_d  = 1'b1;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                S_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = S_ARMED;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                    ctrl_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                    ctrl_d  = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == S_CTRL) || (state_d == S_GUARD);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            hist_q   <= 1'b0;
            pedge_q  <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WW{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            first_q  <= 1'b0;
            freq_q   <= {WW{1'b0}};
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            pedge_q  <= pedge_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            first_q  <= first_d;
            freq_q   <= freq_d;
        end
    end

    assign o_rf_freq      = freq_q;
    assign o_rf_freq_ctrl = ctrl_q;
    assign o_busy         = busy_q;
    assign o_fifo_level   = level_q;
    assign o_ovf          = ovf_q;
    assign o_udf          = udf_q;

endmodule
